// File: rtl/memshare_iblut_remap_loader.sv
// rtl/memshare_iblut_remap_loader.sv - IB-LUT remap loader for a memory-share group (optional error check: MEMSHARE_IBLUT_LOADER_ERRCHK_EN)
module memshare_iblut_remap_loader #(
    parameter int QUAN_SIZE          = 4,
    parameter int SHARE_GROUP_SIZE   = 4,
    parameter int GP1_RAM_ADDR_WIDTH = 5,
    parameter int GP2_RAM_ADDR_WIDTH = 6,
    parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = 4'b1010
) (
    input  logic                                         write_clk,
    input  logic                                         rst,
    input  logic                                         start_i,
    input  logic                                         abort_i,
    input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]        load_data_i,
    input  logic                                         load_valid_i,
    output logic                                         load_ready_o,
    output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]        remap_dataIn_o,
    output logic [GP2_RAM_ADDR_WIDTH*SHARE_GROUP_SIZE-1:0] map_remap_addr_o,
    output logic [SHARE_GROUP_SIZE-1:0]                  remap_en_n_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         err_o
);

    localparam int AW = GP2_RAM_ADDR_WIDTH;
    localparam int A1 = GP1_RAM_ADDR_WIDTH;
    localparam int DW = QUAN_SIZE * SHARE_GROUP_SIZE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     r_state;
    logic [AW-1:0]                  r_addr_cnt;
    logic [DW-1:0]                  r_data;
    logic [AW*SHARE_GROUP_SIZE-1:0] r_addr;
    logic [SHARE_GROUP_SIZE-1:0]    r_en_n;

    logic                           w_accept;
    logic                           w_last;
    logic                           w_gp1_in_range;
    logic [AW-1:0]                  w_gp1_addr;
    logic [AW*SHARE_GROUP_SIZE-1:0] w_lane_addr;
    logic [SHARE_GROUP_SIZE-1:0]    w_lane_en_n;

    assign w_accept       = load_valid_i & (r_state == S_LOAD);
    assign w_last         = (r_addr_cnt == {AW{1'b1}});
    // GP1 RAMs are shallower: only the low half-space of the counter lands in them
    assign w_gp1_in_range = ~|r_addr_cnt[AW-1:A1];
    assign w_gp1_addr     = {{(AW-A1){1'b0}}, r_addr_cnt[A1-1:0]};

    // Per-lane address and enable selection by lane type
    for (genvar k = 0; k < SHARE_GROUP_SIZE; k++) begin : g_lane
        if (SHARE_COL_CONFIG[k]) begin : g_gp2
            assign w_lane_addr[k*AW +: AW] = r_addr_cnt;
            assign w_lane_en_n[k]          = 1'b0;
        end else begin : g_gp1
            assign w_lane_addr[k*AW +: AW] = w_gp1_addr;
            assign w_lane_en_n[k]          = ~w_gp1_in_range;
        end
    end

    // FSM, address counter and registered write port toward the IB-RAMs
    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr_cnt <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_en_n     <= '1;
        end else begin
            r_en_n <= '1;
            if (w_accept) begin
                r_data     <= load_data_i;
                r_addr     <= w_lane_addr;
                r_en_n     <= w_lane_en_n;
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state    <= S_LOAD;
                        r_addr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    // abort wins over completion so no done pulse follows it
                    if (abort_i)
                        r_state <= S_IDLE;
                    else if (w_accept && w_last)
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEMSHARE_IBLUT_LOADER_ERRCHK_EN
    logic r_err;

    // Sticky flag for beats offered outside a load and restarts during a load
    always_ff @(posedge write_clk) begin
        if (rst)
            r_err <= 1'b0;
        else if ((load_valid_i && (r_state != S_LOAD)) || (start_i && (r_state == S_LOAD)))
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign load_ready_o     = (r_state == S_LOAD);
    assign busy_o           = (r_state == S_LOAD);
    assign done_o           = (r_state == S_DONE);
    assign remap_dataIn_o   = r_data;
    assign map_remap_addr_o = r_addr;
    assign remap_en_n_o     = r_en_n;

endmodule

// File: tb/tb_memshare_iblut_remap_loader.sv
// tb/tb_memshare_iblut_remap_loader.sv - directed self-checking bench for memshare_iblut_remap_loader
module tb_memshare_iblut_remap_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [15:0] load_data_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [15:0] remap_dataIn_o;
    logic [23:0] map_remap_addr_o;
    logic [3:0]  remap_en_n_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    memshare_iblut_remap_loader dut (
        .write_clk        (clk),
        .rst              (rst),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .load_data_i      (load_data_i),
        .load_valid_i     (load_valid_i),
        .load_ready_o     (load_ready_o),
        .remap_dataIn_o   (remap_dataIn_o),
        .map_remap_addr_o (map_remap_addr_o),
        .remap_en_n_o     (remap_en_n_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] lane_addr(input int k);
        return map_remap_addr_o[k*6 +: 6];
    endfunction

    function automatic logic [15:0] rep(input int v);
        logic [3:0] n;
        n = v[3:0];
        return {n, n, n, n};
    endfunction

    task automatic check_idle_outputs(input string name);
        checks++;
        if (remap_en_n_o !== 4'b1111 || remap_dataIn_o !== 16'h0 || map_remap_addr_o !== 24'h0 ||
            busy_o !== 1'b0 || done_o !== 1'b0 || load_ready_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: en_n=%b data=%h addr=%h busy=%b done=%b ready=%b err=%b, required en_n=1111 and all others 0",
                     name, remap_en_n_o, remap_dataIn_o, map_remap_addr_o, busy_o, done_o, load_ready_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; load_valid_i = 1'b0; load_data_i = '0;
        step(); step();
        check_idle_outputs("reset_state");
        rst = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_full_load();
        int cyc;
        int gp2_strobes;
        int gp1_strobes;
        int dones;
        logic [3:0] exp_en;
        start_i = 1'b1;
        step();
        cyc = 1;
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || load_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_enter_load: busy=%b ready=%b, required 1 1", busy_o, load_ready_o);
        end
        gp2_strobes = 0; gp1_strobes = 0; dones = 0;
        load_valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            load_data_i = rep(i);
            step();
            cyc++;
            exp_en = (i < 32) ? 4'b0000 : 4'b0101;
            if (remap_en_n_o[1] == 1'b0 && remap_en_n_o[3] == 1'b0) gp2_strobes++;
            if (remap_en_n_o[0] == 1'b0 && remap_en_n_o[2] == 1'b0) gp1_strobes++;
            if (done_o) dones++;
            checks++;
            if (remap_en_n_o !== exp_en) begin
                errors++;
                $display("FAIL full_en_n beat %0d: got %b, required %b", i, remap_en_n_o, exp_en);
            end
            checks++;
            if (lane_addr(1) !== 6'(i) || lane_addr(3) !== 6'(i) ||
                lane_addr(0) !== 6'(i % 32) || lane_addr(2) !== 6'(i % 32)) begin
                errors++;
                $display("FAIL full_addr beat %0d: got %h, required gp2=%0d gp1=%0d", i, map_remap_addr_o, i, i % 32);
            end
            checks++;
            if (remap_dataIn_o !== rep(i)) begin
                errors++;
                $display("FAIL full_data beat %0d: got %h, required %h", i, remap_dataIn_o, rep(i));
            end
            checks++;
            if (done_o !== (i == 63)) begin
                errors++;
                $display("FAIL full_done beat %0d cycle %0d: got %b, required %b", i, cyc, done_o, i == 63);
            end
        end
        checks++;
        if (cyc !== 65 || gp2_strobes !== 64 || gp1_strobes !== 32 || dones !== 1) begin
            errors++;
            $display("FAIL full_totals: cyc=%0d gp2=%0d gp1=%0d done=%0d, required 65 64 32 1",
                     cyc, gp2_strobes, gp1_strobes, dones);
        end
        load_valid_i = 1'b0;
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || remap_en_n_o !== 4'b1111) begin
            errors++;
            $display("FAIL full_after_done: done=%b busy=%b en_n=%b, required 0 0 1111", done_o, busy_o, remap_en_n_o);
        end
    endtask

    task automatic test_restart();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        load_valid_i = 1'b1;
        load_data_i = 16'h5555;
        step();
        checks++;
        if (remap_en_n_o !== 4'b0000 || lane_addr(3) !== 6'd0 || lane_addr(0) !== 6'd0 || remap_dataIn_o !== 16'h5555) begin
            errors++;
            $display("FAIL restart_first_beat: en_n=%b addr=%h data=%h, required 0000 000000 5555",
                     remap_en_n_o, map_remap_addr_o, remap_dataIn_o);
        end
        load_valid_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_abort_exit: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_stall();
        logic [3:0] pat [4];
        logic [3:0] exp_en [4];
        logic [5:0] exp_addr [4];
        pat      = '{4'd1, 4'd0, 4'd0, 4'd1};
        exp_en   = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
        exp_addr = '{6'd0, 6'd0, 6'd0, 6'd1};
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid_i = pat[i][0];
            load_data_i = rep(i + 8);
            step();
            checks++;
            if (remap_en_n_o !== exp_en[i] || lane_addr(1) !== exp_addr[i] || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL stall step %0d: en_n=%b addr=%0d busy=%b, required %b %0d 1",
                         i, remap_en_n_o, lane_addr(1), busy_o, exp_en[i], exp_addr[i]);
            end
        end
        checks++;
        if (remap_dataIn_o !== rep(11)) begin
            errors++;
            $display("FAIL stall_data: got %h, required %h", remap_dataIn_o, rep(11));
        end
        load_valid_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    task automatic test_abort();
        int writes;
        writes = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        load_valid_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            load_data_i = rep(i);
            abort_i = (i == 10);
            step();
            if (remap_en_n_o[3] == 1'b0) writes++;
            checks++;
            if (lane_addr(3) !== 6'(i) || busy_o !== (i != 10)) begin
                errors++;
                $display("FAIL abort beat %0d: addr=%0d busy=%b, required %0d %b", i, lane_addr(3), busy_o, i, i != 10);
            end
        end
        abort_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (remap_en_n_o[3] == 1'b0) writes++;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || load_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_after %0d: done=%b busy=%b ready=%b, required 0 0 0", i, done_o, busy_o, load_ready_o);
            end
        end
        checks++;
        if (writes !== 11) begin
            errors++;
            $display("FAIL abort_writes: got %0d, required 11", writes);
        end
        load_valid_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        load_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            load_data_i = rep(i);
            step();
        end
        checks++;
        if (lane_addr(1) !== 6'd19 || remap_en_n_o !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_pre: addr=%0d en_n=%b, required 19 0000", lane_addr(1), remap_en_n_o);
        end
        rst = 1'b1;
        load_data_i = rep(20);
        step();
        check_idle_outputs("midrst_reset_cycle");
        rst = 1'b0;
        load_valid_i = 1'b0;
        step();
        check_idle_outputs("midrst_after");
    endtask

    task automatic test_error();
        logic exp_err;
`ifdef MEMSHARE_IBLUT_LOADER_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        load_valid_i = 1'b1;
        step();
        load_valid_i = 1'b0;
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL err_set: got %b, required %b", err_o, exp_err);
        end
        step(); step();
        checks++;
        if (err_o !== exp_err || remap_en_n_o !== 4'b1111) begin
            errors++;
            $display("FAIL err_sticky: err=%b en_n=%b, required %b 1111", err_o, remap_en_n_o, exp_err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b, required 0", err_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_restart();
        test_stall();
        test_abort();
        test_mid_reset();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memshare_iblut_remap_loader.md
MEMSHARE_IBLUT_REMAP_LOADER -- requirements
Module: memShare_ibLUT_remap_loader

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 4, message width per VN lane.
REQ-002 SHALL have parameter SHARE_GROUP_SIZE, default 4, number of VN lanes in a share group.
REQ-003 SHALL have parameter GP1_RAM_ADDR_WIDTH, default 5, GP1 IB-RAM address width.
REQ-004 SHALL have parameter GP2_RAM_ADDR_WIDTH, default 6, GP2 IB-RAM address width; must exceed GP1_RAM_ADDR_WIDTH.
REQ-005 SHALL have parameter SHARE_COL_CONFIG, default 4'b1010, per-lane type: bit=1 is GP2, bit=0 is GP1.
REQ-006 SHALL have port write_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start_i, input, 1, single-cycle request to begin a full remap load.
REQ-009 SHALL have port abort_i, input, 1, terminates an in-progress load.
REQ-010 SHALL have port load_data_i, input, QUAN_SIZE*SHARE_GROUP_SIZE, one IB-LUT entry per lane, with lane k in bits [(k+1)*QUAN_SIZE-1 : k*QUAN_SIZE].
REQ-011 SHALL have port load_valid_i, input, 1, upstream beat valid.
REQ-012 SHALL have port load_ready_o, output, 1, loader accepts beat.
REQ-013 SHALL have port remap_dataIn_o, output, QUAN_SIZE*SHARE_GROUP_SIZE, write data to IB-RAM lanes.
REQ-014 SHALL have port map_remap_addr_o, output, GP2_RAM_ADDR_WIDTH*SHARE_GROUP_SIZE, per-lane write address.
REQ-015 SHALL have port remap_en_n_o, output, SHARE_GROUP_SIZE, per-lane write enable, active LOW.
REQ-016 SHALL have port busy_o, output, 1, high while in LOAD.
REQ-017 SHALL have port done_o, output, 1, one-cycle pulse on completion.
REQ-018 SHALL have port err_o, output, 1, sticky protocol error (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-020 SHALL transition IDLE->LOAD on start_i=1 and clear the address counter addr_cnt (GP2_RAM_ADDR_WIDTH bits) to 0; start_i SHALL be ignored in LOAD and DONE.
REQ-021 SHALL drive load_ready_o=1 only in LOAD; a beat is accepted when load_valid_i & load_ready_o.
REQ-022 SHALL, on an accepted beat, register load_data_i into remap_dataIn_o and addr_cnt into every lane of map_remap_addr_o, and then increment addr_cnt; write strobes appear exactly 1 cycle after acceptance.
REQ-023 SHALL, in that write cycle, drive remap_en_n_o[k]=0 for GP2 lanes, and for GP1 lanes only when the accepted addr_cnt < 2**GP1_RAM_ADDR_WIDTH; otherwise it SHALL drive 1.
REQ-024 SHALL zero the GP1 lane address bits above GP1_RAM_ADDR_WIDTH-1.
REQ-025 SHALL drive all remap_en_n_o bits to 1 in every cycle without an accepted beat in the previous cycle; data and address outputs SHALL hold their last values.
REQ-026 SHALL treat load_valid_i=0 in LOAD as a stall, with no counter advance and no write.
REQ-027 SHALL go LOAD->DONE when the beat at addr_cnt = 2**GP2_RAM_ADDR_WIDTH-1 is accepted; addr_cnt wraps to 0.
REQ-028 SHALL assert done_o=1 for exactly the single DONE cycle, coincident with the final write strobe, then return to IDLE.
REQ-029 SHALL, on abort_i=1 in LOAD, go to IDLE the next cycle with no done_o; a beat accepted in the same cycle as the abort SHALL still be written, and no later beats SHALL be accepted.
REQ-030 SHALL give abort_i priority over completion when both occur in the same cycle, so done_o is not asserted.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, set state=IDLE, addr_cnt=0, load_ready_o=0, remap_en_n_o=all 1s, remap_dataIn_o=0, map_remap_addr_o=0, busy_o=0, done_o=0 and err_o=0.
REQ-032 SHALL abandon a load when reset occurs mid-LOAD; no write strobe follows the reset cycle.

Configuration
REQ-033 SHALL, with macro MEMSHARE_IBLUT_LOADER_ERRCHK_EN defined, set err_o (sticky until rst) when load_valid_i=1 in IDLE or DONE, or when start_i=1 in LOAD.
REQ-034 SHALL, without MEMSHARE_IBLUT_LOADER_ERRCHK_EN, tie err_o to 0 and include no error logic.

Verification
REQ-035 SHALL cover full load: start, 64 back-to-back beats with data=addr replicated per lane -> lanes 1/3 strobe 64 times at addr 0..63, lanes 0/2 strobe 32 times at addr 0..31, and done_o pulses once, 65 cycles after start.
REQ-036 SHALL cover stalls: load_valid_i toggled 1,0,0,1 -> writes only on the accepted beats, with addr_cnt unchanged during stalls.
REQ-037 SHALL cover abort: abort_i at beat 10 with valid held high -> 11 writes (addr 0..10), busy_o falls, and no done_o.
REQ-038 SHALL cover mid-LOAD reset: rst at beat 20 -> all remap_en_n_o=4'b1111 the next cycle and all outputs at reset values.
REQ-039 SHALL cover the error path: with MEMSHARE_IBLUT_LOADER_ERRCHK_EN, load_valid_i=1 in IDLE -> err_o=1 and it stays 1 until rst; without the macro, err_o=0.
REQ-040 SHALL cover restart: start_i in the cycle after done_o -> new load begins at addr 0.
